mem_wb_retire: RTL and testbench



---
 rtl/mem_wb_retire.sv | 123 ++++++++++++
 tb/tb_mem_wb_retire.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_retire.sv
// MEM/WB pipeline register with the architectural HI/LO pair, HI/LO bypass to EX
// and a retired-instruction counter.
module mem_wb_retire #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_mem,
    input  logic                stall_wb,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic [4:0]          mem_wd,
    input  logic                mem_wreg,
    input  logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_hi,
    input  logic [31:0]         mem_lo,
    input  logic                mem_whilo,
    output logic [4:0]          wb_wd,
    output logic                wb_wreg,
    output logic [31:0]         wb_wdata,
    output logic [31:0]         hi_o,
    output logic [31:0]         lo_o,
    output logic [31:0]         hilo_fwd_hi,
    output logic [31:0]         hilo_fwd_lo,
    output logic [RETIRE_W-1:0] retired_cnt
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0]   wd_q,     wd_d;
    logic                wreg_q,   wreg_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   whi_q,    whi_d;
    logic [DATA_W-1:0]   wlo_q,    wlo_d;
    logic                whilo_q,  whilo_d;
    logic                valid_q,  valid_d;
    logic [DATA_W-1:0]   hi_q,     hi_d;
    logic [DATA_W-1:0]   lo_q,     lo_d;
    logic [RETIRE_W-1:0] cnt_q,    cnt_d;
    logic                commit;

    // The instruction in WB leaves the stage (and retires) on this edge.
    assign commit = valid_q & ~stall_wb & ~flush;

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whi_d   = whi_q;
        wlo_d   = wlo_q;
        whilo_d = whilo_q;
        valid_d = valid_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;

        if (commit) begin
            cnt_d = cnt_q + RETIRE_W'(1);
            if (whilo_q) begin
                hi_d = whi_q;
                lo_d = wlo_q;
            end
        end

        // Bubble on flush or when MEM holds while WB drains; hold when both stall.
        if (flush || (stall_mem && !stall_wb)) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            whi_d   = '0;
            wlo_d   = '0;
            whilo_d = 1'b0;
            valid_d = 1'b0;
        end else if (!stall_mem) begin
            wd_d    = mem_wd;
            wreg_d  = mem_wreg & mem_valid;
            wdata_d = mem_wdata;
            whi_d   = mem_hi;
            wlo_d   = mem_lo;
            whilo_d = mem_whilo & mem_valid;
            valid_d = mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            whi_q   <= '0;
            wlo_q   <= '0;
            whilo_q <= 1'b0;
            valid_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whi_q   <= whi_d;
            wlo_q   <= wlo_d;
            whilo_q <= whilo_d;
            valid_q <= valid_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_wd       = wd_q;
    assign wb_wreg     = wreg_q;
    assign wb_wdata    = wdata_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign retired_cnt = cnt_q;

    // WB-stage HI/LO is younger than the architectural copy until it commits.
    assign hilo_fwd_hi = (valid_q & whilo_q) ? whi_q : hi_q;
    assign hilo_fwd_lo = (valid_q & whilo_q) ? wlo_q : lo_q;

endmodule

// File: tb/tb_mem_wb_retire.sv
// Scoreboard bench for mem_wb_retire: a behavioural model predicts each edge,
// expectations are queued at drive time and compared one edge later.
module tb_mem_wb_retire;

    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst, stall_mem, stall_wb, flush;
    logic          mem_valid, mem_wreg, mem_whilo;
    logic [4:0]    mem_wd;
    logic [31:0]   mem_wdata, mem_hi, mem_lo;
    logic [4:0]    wb_wd;
    logic          wb_wreg;
    logic [31:0]   wb_wdata, hi_o, lo_o, hilo_fwd_hi, hilo_fwd_lo;
    logic [RW-1:0] retired_cnt;

    mem_wb_retire #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush(flush), .mem_valid(mem_valid), .mem_wd(mem_wd),
        .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .wb_wd(wb_wd),
        .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .hi_o(hi_o), .lo_o(lo_o),
        .hilo_fwd_hi(hilo_fwd_hi), .hilo_fwd_lo(hilo_fwd_lo),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    wd;
        logic          wreg;
        logic [31:0]   wdata, hi, lo, fhi, flo;
        logic [RW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Model state
    logic [4:0]    m_wd;
    logic          m_wreg, m_whilo, m_valid;
    logic [31:0]   m_wdata, m_whi, m_wlo, m_hi, m_lo;
    logic [RW-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Predict the post-edge state from model state and current inputs.
    task automatic model_edge();
        exp_t e;
        if (rst) begin
            m_wd = '0; m_wreg = 0; m_wdata = '0; m_whi = '0; m_wlo = '0;
            m_whilo = 0; m_valid = 0; m_hi = '0; m_lo = '0; m_cnt = '0;
        end else begin
            if (m_valid && !stall_wb && !flush) begin
                m_cnt = m_cnt + 1'b1;
                if (m_whilo) begin
                    m_hi = m_whi;
                    m_lo = m_wlo;
                end
            end
            if (flush || (stall_mem && !stall_wb)) begin
                m_wd = '0; m_wreg = 0; m_wdata = '0; m_whi = '0; m_wlo = '0;
                m_whilo = 0; m_valid = 0;
            end else if (!stall_mem) begin
                m_wd = mem_wd; m_wdata = mem_wdata; m_whi = mem_hi; m_wlo = mem_lo;
                m_wreg = mem_wreg && mem_valid;
                m_whilo = mem_whilo && mem_valid;
                m_valid = mem_valid;
            end
        end
        e.wd = m_wd; e.wreg = m_wreg; e.wdata = m_wdata; e.hi = m_hi; e.lo = m_lo;
        e.fhi = (m_valid && m_whilo) ? m_whi : m_hi;
        e.flo = (m_valid && m_whilo) ? m_wlo : m_lo;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("wb_wd",    32'(wb_wd),       32'(e.wd));
            check_eq("wb_wreg",  32'(wb_wreg),     32'(e.wreg));
            check_eq("wb_wdata", wb_wdata,         e.wdata);
            check_eq("hi_o",     hi_o,             e.hi);
            check_eq("lo_o",     lo_o,             e.lo);
            check_eq("fwd_hi",   hilo_fwd_hi,      e.fhi);
            check_eq("fwd_lo",   hilo_fwd_lo,      e.flo);
            check_eq("cnt",      32'(retired_cnt), 32'(e.cnt));
        end
    endtask

    task automatic ctl(input logic r, input logic sm, input logic sw, input logic fl);
        rst = r; stall_mem = sm; stall_wb = sw; flush = fl;
    endtask

    task automatic instr(input logic v, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic whilo,
                         input logic [31:0] hi, input logic [31:0] lo);
        mem_valid = v; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
    endtask

    initial begin
        m_wd = '0; m_wreg = 0; m_wdata = '0; m_whi = '0; m_wlo = '0;
        m_whilo = 0; m_valid = 0; m_hi = '0; m_lo = '0; m_cnt = '0;
        ctl(1, 0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        #2;
        cycle(); cycle();
        check_eq("rst_cnt", 32'(retired_cnt), 32'd0);

        // Basic capture, then HI/LO write with bypass
        ctl(0, 0, 0, 0);
        instr(1, 5'd5, 1, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        check_eq("cap_wd", 32'(wb_wd), 32'd5);
        check_eq("cap_wdata", wb_wdata, 32'hDEADBEEF);
        instr(1, 5'd6, 0, 32'h0, 1, 32'h11111111, 32'h22222222);
        cycle();
        check_eq("ret1_cnt", 32'(retired_cnt), 32'd1);
        check_eq("byp_hi", hilo_fwd_hi, 32'h11111111);
        check_eq("byp_hi_arch", hi_o, 32'h0);
        instr(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_eq("arch_hi", hi_o, 32'h11111111);
        check_eq("arch_lo", lo_o, 32'h22222222);

        // Full stall holds WB; retires once on release
        instr(1, 5'd7, 1, 32'hCAFEF00D, 0, 0, 0);
        cycle();
        ctl(0, 1, 1, 0);
        instr(1, 5'd9, 1, 32'h99999999, 0, 0, 0);
        repeat (3) cycle();
        check_eq("hold_wd", 32'(wb_wd), 32'd7);
        check_eq("hold_cnt", 32'(retired_cnt), 32'd2);
        ctl(0, 0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_eq("rel_cnt", 32'(retired_cnt), 32'd3);

        // MEM stall with WB draining inserts bubbles
        instr(1, 5'd10, 1, 32'h12345678, 0, 0, 0);
        cycle();
        ctl(0, 1, 0, 0);
        cycle();
        check_eq("bub_wreg", 32'(wb_wreg), 32'd0);
        check_eq("bub_wd", 32'(wb_wd), 32'd0);
        cycle();
        check_eq("bub_cnt", 32'(retired_cnt), 32'd4);

        // Flush kills a pending WB HI/LO write
        ctl(0, 0, 0, 0);
        instr(1, 5'd11, 0, 32'h0, 1, 32'hAAAA0000, 32'h0000BBBB);
        cycle();
        ctl(0, 0, 0, 1);
        instr(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_eq("fl_hi", hi_o, 32'h11111111);
        check_eq("fl_cnt", 32'(retired_cnt), 32'd4);
        check_eq("fl_fwd", hilo_fwd_hi, 32'h11111111);

        // Back-to-back HI/LO writes
        ctl(0, 0, 0, 0);
        instr(1, 0, 0, 0, 1, 32'hF0000001, 32'hE0000001);
        cycle();
        instr(1, 0, 0, 0, 1, 32'hF0000002, 32'hE0000002);
        cycle();
        check_eq("b2b_fwd", hilo_fwd_hi, 32'hF0000002);
        check_eq("b2b_arch", hi_o, 32'hF0000001);
        instr(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Randomised traffic (no illegal stall combination)
        for (int i = 0; i < 60; i++) begin
            logic sm, sw;
            sm = ($urandom_range(0, 3) == 0);
            sw = sm && ($urandom_range(0, 1) == 1);
            ctl(0, sm, sw, $urandom_range(0, 9) == 0);
            instr($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), $urandom,
                  1'($urandom), $urandom, $urandom);
            cycle();
        end

        // Counter wrap with a 4-bit counter
        ctl(1, 0, 0, 0);
        cycle();
        ctl(0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            instr(1, 5'(i), 1, 32'(i), 0, 0, 0);
            cycle();
        end
        instr(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_eq("wrap_cnt", 32'(retired_cnt), 32'd1);

        // Reset while stalled with a HI/LO write held in WB
        instr(1, 5'd3, 1, 32'h3, 1, 32'h77777777, 32'h88888888);
        cycle();
        cycle();
        ctl(0, 1, 1, 0);
        cycle();
        ctl(1, 1, 1, 0);
        cycle();
        check_eq("rst_mid_cnt", 32'(retired_cnt), 32'd0);
        check_eq("rst_mid_hi", hi_o, 32'h0);
        check_eq("rst_mid_lo", lo_o, 32'h0);
        ctl(0, 0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
